self_attention_seq: RTL and testbench
=====================================

# self_attention_seq

Slice-level sequencer for one self-attention head. On `start` it runs each row slice through the head datapath in a fixed order:

- Q/K/V projection
- QK^T score
- softmax
- score×V
- b2r drain

It then pulses the b2r wrapper's internal soft reset before moving to the next slice. It sits between the multi-head attention top-level control and the self-attention head datapath, and drives the b2r wrapper's `internal_rst_n_b2r`.

## Interface

Parameters:

- `NUM_SLICES`, default 4: row slices per head computation (≥1).
- `SLICE_W`, default 2: width of `slice_idx`; must be ≥ max(1, $clog2(NUM_SLICES)).
- `RST_PULSE_LEN`, default 2: cycles `internal_rst_n_b2r` is held low per slice (≥1).

Ports:

- `clk`  in  1  — single clock, all logic on rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `start`  in  1  — begin head computation; sampled only in IDLE.
- `busy`  out  1  — high while not in IDLE.
- `done`  out  1  — one-cycle pulse when the last slice completes.
- `err`  out  1  — sticky protocol-violation flag.
- `slice_idx`  out  SLICE_W  — current slice number.
- `qkv_start` / `qkv_done`  out/in  1  — Q/K/V projection launch / completion pulse.
- `score_start` / `score_done`  out/in  1  — QK^T launch / completion pulse.
- `softmax_start` / `softmax_done`  out/in  1  — softmax launch / completion pulse.
- `av_start` / `av_done`  out/in  1  — score×V launch / completion pulse.
- `slice_done_b2r_wrap`  in  1  — b2r wrapper has finished draining the current slice.
- `internal_rst_n_b2r`  out  1  — active-low soft reset to the b2r wrapper.

## Operation

States: IDLE, QKV, SCORE, SOFTMAX, AV, B2R_WAIT, B2R_RST.

Transitions:

- IDLE: `start`=1 → QKV with `slice_idx`=0, `err` cleared.
- QKV: `qkv_done` → SCORE.
- SCORE: `score_done` → SOFTMAX.
- SOFTMAX: `softmax_done` → AV.
- AV: `av_done` → B2R_WAIT.
- B2R_WAIT: `slice_done_b2r_wrap` → B2R_RST.
- B2R_RST: held exactly RST_PULSE_LEN cycles using an internal counter. Then:
  - if `slice_idx`==NUM_SLICES-1 → IDLE and pulse `done`;
  - else increment `slice_idx` → QKV.

Stage handshake:

- Each `*_start` is high for exactly one cycle: the first cycle the FSM is in the matching state.
- The matching `*_done` is accepted in any cycle of that state, including the start cycle.

Behaviour of inputs outside their state:

- A `*_done` arriving while the FSM is not in its matching state is ignored for sequencing and sets `err`. `err` stays set until the next accepted `start`.
- `slice_done_b2r_wrap` outside B2R_WAIT is ignored and does not set `err`.
- `start` while busy is ignored.

`internal_rst_n_b2r` is registered:

- 0 in every B2R_RST cycle.
- 1 in all other states.

`slice_idx` holds its value in IDLE after `done`. It is rewritten to 0 on the next accepted `start`.

## Timing

Cycle numbering: cycle 0 is the IDLE cycle in which `start` is sampled high. Slice 0 enters QKV in cycle 1.

Reset values, applied asynchronously while `rst_n`=0:

- state=IDLE, `busy`=0, `done`=0, `err`=0, `slice_idx`=0.
- All `*_start`=0.
- `internal_rst_n_b2r`=0 (b2r held in reset).
- After `rst_n` deasserts, `internal_rst_n_b2r` goes to 1 at the first rising edge.

Cycle-level rules:

- `busy` is high from cycle 1 through the last B2R_RST cycle.
- `done` is high in the first IDLE cycle that follows.
- Minimum per-slice latency, with every done returned in its entry cycle: 5 + RST_PULSE_LEN cycles.
- Total minimum latency: NUM_SLICES × (5 + RST_PULSE_LEN). With defaults this is 28 busy cycles (1..28) and `done` in cycle 29.
- `start` sampled high in the same cycle `done` is high (IDLE) is accepted: QKV is entered next cycle.
- Reset mid-operation aborts immediately:
  - no `done` pulse;
  - any in-flight `*_start` is dropped;
  - `internal_rst_n_b2r` is forced to 0.

## Test plan

- NUM_SLICES=1, RST_PULSE_LEN=2, every done and `slice_done_b2r_wrap` driven in the state's entry cycle:
  - start strobes in cycles 1, 2, 3, 4;
  - `internal_rst_n_b2r`=0 in cycles 6–7;
  - `done` in cycle 8; `busy` high in cycles 1–7.
- Defaults, each stage done delayed by 3–10 random cycles → four full slice sequences, `slice_idx` 0,1,2,3, and exactly one `done`, issued after the fourth B2R_RST.
- `start` pulsed in SCORE of slice 1 → no state or `slice_idx` change; the run completes normally with a single `done`.
- `av_done` pulsed during SOFTMAX → `err`=1 from the next cycle; FSM stays in SOFTMAX until `softmax_done`; `err` cleared by the next accepted `start`.
- `slice_done_b2r_wrap` pulsed during SCORE, then again in B2R_WAIT → the first pulse is ignored and `err` stays 0; the second pulse moves the FSM to B2R_RST.
- `rst_n` dropped during B2R_RST of slice 2 → all outputs at reset values asynchronously (`internal_rst_n_b2r`=0, `slice_idx`=0); after release a fresh `start` runs from slice 0.

Source files
------------

// File: rtl/self_attention_seq.sv
// Slice-level sequencer for one self-attention head: walks every row slice through
// QKV -> score -> softmax -> score*V -> b2r drain, then pulses the b2r soft reset.
module self_attention_seq #(
    parameter int NUM_SLICES    = 4,
    parameter int SLICE_W       = 2,
    parameter int RST_PULSE_LEN = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [SLICE_W-1:0] slice_idx,
    output logic               qkv_start,
    input  logic               qkv_done,
    output logic               score_start,
    input  logic               score_done,
    output logic               softmax_start,
    input  logic               softmax_done,
    output logic               av_start,
    input  logic               av_done,
    input  logic               slice_done_b2r_wrap,
    output logic               internal_rst_n_b2r
);

    localparam int CNT_W = (RST_PULSE_LEN > 1) ? $clog2(RST_PULSE_LEN) : 1;
    localparam logic [SLICE_W-1:0] LAST_SLICE = SLICE_W'(NUM_SLICES - 1);
    localparam logic [CNT_W-1:0]   LAST_CNT   = CNT_W'(RST_PULSE_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_QKV,
        S_SCORE,
        S_SOFTMAX,
        S_AV,
        S_B2R_WAIT,
        S_B2R_RST
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] rst_cnt;
    logic             stray_done;

    // A stage completion outside its own stage is a protocol violation.
    assign stray_done = (qkv_done     && (state != S_QKV))     ||
                        (score_done   && (state != S_SCORE))   ||
                        (softmax_done && (state != S_SOFTMAX)) ||
                        (av_done      && (state != S_AV));

    // NOTE: every register here is state, so all assignments are non-blocking;
    // the pulse outputs get a default at the top and are raised only on a transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            rst_cnt            <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            err                <= 1'b0;
            slice_idx          <= '0;
            qkv_start          <= 1'b0;
            score_start        <= 1'b0;
            softmax_start      <= 1'b0;
            av_start           <= 1'b0;
            internal_rst_n_b2r <= 1'b0;
        end else begin
            qkv_start          <= 1'b0;
            score_start        <= 1'b0;
            softmax_start      <= 1'b0;
            av_start           <= 1'b0;
            done               <= 1'b0;
            internal_rst_n_b2r <= 1'b1;

            if (stray_done) begin
                err <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_QKV;
                        slice_idx <= '0;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        qkv_start <= 1'b1;
                    end
                end
                S_QKV: begin
                    if (qkv_done) begin
                        state       <= S_SCORE;
                        score_start <= 1'b1;
                    end
                end
                S_SCORE: begin
                    if (score_done) begin
                        state         <= S_SOFTMAX;
                        softmax_start <= 1'b1;
                    end
                end
                S_SOFTMAX: begin
                    if (softmax_done) begin
                        state    <= S_AV;
                        av_start <= 1'b1;
                    end
                end
                S_AV: begin
                    if (av_done) begin
                        state <= S_B2R_WAIT;
                    end
                end
                S_B2R_WAIT: begin
                    if (slice_done_b2r_wrap) begin
                        state              <= S_B2R_RST;
                        rst_cnt            <= '0;
                        internal_rst_n_b2r <= 1'b0;
                    end
                end
                S_B2R_RST: begin
                    if (rst_cnt == LAST_CNT) begin
                        if (slice_idx == LAST_SLICE) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state     <= S_QKV;
                            slice_idx <= slice_idx + 1'b1;
                            qkv_start <= 1'b1;
                        end
                    end else begin
                        rst_cnt            <= rst_cnt + 1'b1;
                        internal_rst_n_b2r <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_self_attention_seq.sv
// Scoreboard bench for self_attention_seq: a 1-slice instance for exact cycle timing
// and a default instance driven with random stage latencies, pokes and a mid-run reset.
module tb_self_attention_seq;

    localparam int NS  = 4;
    localparam int RPL = 2;
    localparam int TMO = 200;
    localparam int POKE_NONE  = 0;
    localparam int POKE_START = 1;
    localparam int POKE_ERR   = 2;
    localparam int POKE_B2R   = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, err;
    logic [1:0] slice_idx;
    logic       qkv_start, score_start, softmax_start, av_start;
    logic       qkv_done = 1'b0, score_done = 1'b0, softmax_done = 1'b0, av_done = 1'b0;
    logic       slice_done_b2r_wrap = 1'b0;
    logic       internal_rst_n_b2r;

    logic       d1_start = 1'b0;
    logic       d1_busy, d1_done, d1_err;
    logic [0:0] d1_slice_idx;
    logic       d1_qkv_start, d1_score_start, d1_softmax_start, d1_av_start;
    logic       d1_qkv_done = 1'b0, d1_score_done = 1'b0, d1_softmax_done = 1'b0, d1_av_done = 1'b0;
    logic       d1_b2r = 1'b0, d1_av_prev = 1'b0;
    logic       d1_internal_rst_n_b2r;

    int checks = 0;
    int failures = 0;
    int sb_q[$];
    bit mon_en = 1'b0;
    logic b2r_prev = 1'b0;

    always #5 clk = ~clk;

    self_attention_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
        .slice_idx(slice_idx),
        .qkv_start(qkv_start), .qkv_done(qkv_done),
        .score_start(score_start), .score_done(score_done),
        .softmax_start(softmax_start), .softmax_done(softmax_done),
        .av_start(av_start), .av_done(av_done),
        .slice_done_b2r_wrap(slice_done_b2r_wrap),
        .internal_rst_n_b2r(internal_rst_n_b2r)
    );

    self_attention_seq #(.NUM_SLICES(1), .SLICE_W(1), .RST_PULSE_LEN(2)) dut_one (
        .clk(clk), .rst_n(rst_n), .start(d1_start), .busy(d1_busy), .done(d1_done), .err(d1_err),
        .slice_idx(d1_slice_idx),
        .qkv_start(d1_qkv_start), .qkv_done(d1_qkv_done),
        .score_start(d1_score_start), .score_done(d1_score_done),
        .softmax_start(d1_softmax_start), .softmax_done(d1_softmax_done),
        .av_start(d1_av_start), .av_done(d1_av_done),
        .slice_done_b2r_wrap(d1_b2r),
        .internal_rst_n_b2r(d1_internal_rst_n_b2r)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Zero-latency responder for the 1-slice instance: every done in its stage's entry cycle.
    always @(negedge clk) begin
        d1_b2r          = d1_av_prev;
        d1_av_prev      = d1_av_start;
        d1_qkv_done     = d1_qkv_start;
        d1_score_done   = d1_score_start;
        d1_softmax_done = d1_softmax_start;
        d1_av_done      = d1_av_start;
    end

    task automatic sb_check(input int kind);
        int got;
        int exp;
        got = kind * 16 + int'(slice_idx);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : -1;
        check("sb_event", 32'(got), 32'(exp));
    endtask

    // Event monitor: stage launches, b2r reset assertion and done, in order, tagged with slice.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (qkv_start)     sb_check(0);
            if (score_start)   sb_check(1);
            if (softmax_start) sb_check(2);
            if (av_start)      sb_check(3);
            if (b2r_prev && !internal_rst_n_b2r) sb_check(4);
            if (done)          sb_check(5);
        end
        b2r_prev = internal_rst_n_b2r;
    end

    function automatic logic strobe(input int k);
        case (k)
            0: return qkv_start;
            1: return score_start;
            2: return softmax_start;
            3: return av_start;
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_done(input int k, input logic v);
        case (k)
            0: qkv_done = v;
            1: score_done = v;
            2: softmax_done = v;
            3: av_done = v;
            4: slice_done_b2r_wrap = v;
            default: ;
        endcase
    endtask

    task automatic pulse(input int k);
        set_done(k, 1'b1);
        @(negedge clk);
        set_done(k, 1'b0);
    endtask

    task automatic wait_strobe(input int k, output int waited);
        waited = 0;
        while (strobe(k) !== 1'b1 && waited < TMO) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic rand_wait(input int min_d, input int max_d);
        int d;
        d = (max_d > 0) ? int'($urandom_range(max_d, min_d)) : 0;
        repeat (d) @(negedge clk);
    endtask

    task automatic run_head(input int min_d, input int max_d, input int poke,
                            input int abort_slice, input bit b2b);
        int w;
        int lows;
        for (int s = 0; s < NS; s++)
            for (int k = 0; k < 5; k++) sb_q.push_back(k * 16 + s);
        sb_q.push_back(5 * 16 + NS - 1);

        if (!b2b) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_clr", 32'(err), 32'd0);
        check("busy_on", 32'(busy), 32'd1);

        for (int s = 0; s < NS; s++) begin
            for (int k = 0; k < 4; k++) begin
                wait_strobe(k, w);
                check("stage_latency", 32'(w), 32'd0);
                check("slice_idx", 32'(slice_idx), 32'(s));
                if (poke == POKE_START && s == 1 && k == 1) begin
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                    check("busy_start_idx", 32'(slice_idx), 32'd1);
                    check("busy_start_strobes", 32'({qkv_start, score_start}), 32'd0);
                end
                if (poke == POKE_ERR && s == 0 && k == 2) begin
                    pulse(3);
                    check("err_set", 32'(err), 32'd1);
                    check("hold_softmax", 32'(av_start), 32'd0);
                end
                if (poke == POKE_B2R && s == 0 && k == 1) begin
                    pulse(4);
                    check("b2r_stray_err", 32'(err), 32'd0);
                end
                rand_wait(min_d, max_d);
                pulse(k);
            end
            check("b2r_wait_rst_hi", 32'(internal_rst_n_b2r), 32'd1);
            rand_wait(min_d, max_d);
            pulse(4);
            if (s == abort_slice) return;
            lows = 0;
            while (internal_rst_n_b2r === 1'b0 && lows < 50) begin
                lows++;
                @(negedge clk);
            end
            check("rst_pulse_len", 32'(lows), 32'(RPL));
        end
        check("done_pulse", 32'(done), 32'd1);
        check("busy_off", 32'(busy), 32'd0);
        if (poke == POKE_ERR) check("err_sticky", 32'(err), 32'd1);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        logic [6:0] exp_vec;

        #1;
        check("rst_outs", 32'({busy, done, err, qkv_start, score_start, softmax_start,
                              av_start, internal_rst_n_b2r}), 32'd0);
        check("rst_idx", 32'(slice_idx), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("b2r_rst_hold", 32'(internal_rst_n_b2r), 32'd0);
        @(negedge clk);
        check("b2r_rst_release", 32'(internal_rst_n_b2r), 32'd1);
        mon_en = 1'b1;

        // Single-slice instance: cycle-exact strobes, b2r reset window, done and busy.
        d1_start = 1'b1;
        @(negedge clk);
        d1_start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            exp_vec = {c == 1, c == 2, c == 3, c == 4, !(c == 6 || c == 7), c == 8,
                       (c >= 1 && c <= 7)};
            check($sformatf("one_slice_c%0d", c),
                  32'({d1_qkv_start, d1_score_start, d1_softmax_start, d1_av_start,
                       d1_internal_rst_n_b2r, d1_done, d1_busy}), 32'(exp_vec));
            @(negedge clk);
        end
        check("one_slice_err", 32'(d1_err), 32'd0);
        check("one_slice_idx", 32'(d1_slice_idx), 32'd0);

        run_head(3, 10, POKE_NONE, -1, 1'b0);
        run_head(0, 3, POKE_START, -1, 1'b1);
        run_head(1, 4, POKE_ERR, -1, 1'b0);
        run_head(0, 2, POKE_B2R, -1, 1'b0);

        // Abort in B2R_RST of slice 2, then a clean run from slice 0.
        run_head(0, 2, POKE_NONE, 2, 1'b0);
        check("pre_abort_idx", 32'(slice_idx), 32'd2);
        #2;
        mon_en = 1'b0;
        sb_q.delete();
        rst_n = 1'b0;
        #1;
        check("abort_outs", 32'({busy, done, err, qkv_start, score_start, softmax_start,
                                av_start, internal_rst_n_b2r}), 32'd0);
        check("abort_idx", 32'(slice_idx), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("abort_no_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_b2r_release", 32'(internal_rst_n_b2r), 32'd1);
        mon_en = 1'b1;
        run_head(0, 0, POKE_NONE, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
